// File: rtl/udp_tx_pkt_buf_if.sv
// Write/transmit handshake bundle for udp_tx_pkt_buf.
// The master side is user logic plus the UDP transmitter; the slave side is the buffer.
interface udp_tx_pkt_buf_if #(
  parameter int LEN_FIFO_W = 3
);
  logic                wr_en;
  logic [7:0]          wr_data;
  logic                wr_last;
  logic                wr_commit;
  logic                wr_drop;
  logic                tx_start_en;
  logic [15:0]         tx_byte_num;
  logic                tx_req;
  logic [7:0]          tx_data;
  logic                tx_done;
  logic                tx_abort;
  logic [LEN_FIFO_W:0] pkt_pending;

  modport master (
    output wr_en, wr_data, wr_last, tx_req, tx_done,
    input  wr_commit, wr_drop, tx_start_en, tx_byte_num, tx_data, tx_abort, pkt_pending
  );

  modport slave (
    input  wr_en, wr_data, wr_last, tx_req, tx_done,
    output wr_commit, wr_drop, tx_start_en, tx_byte_num, tx_data, tx_abort, pkt_pending
  );
endinterface

// File: rtl/udp_tx_pkt_buf.sv
// Store-and-forward payload buffer feeding the UDP transmitter (gmii_tx_clk domain).
// Optional statistics counters are enabled with the UDP_TX_PKT_BUF_STATS_EN macro.
module udp_tx_pkt_buf #(
  parameter int ADDR_W      = 11,
  parameter int LEN_FIFO_W  = 3,
  parameter int MAX_PKT_LEN = 1472,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  udp_tx_pkt_buf_if.slave        bus
`ifdef UDP_TX_PKT_BUF_STATS_EN
  ,
  output logic [31:0]            o_stat_tx_pkts,
  output logic [31:0]            o_stat_drops,
  output logic [15:0]            o_stat_aborts
`endif
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NDESC = 1 << LEN_FIFO_W;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [7:0]          r_ram  [DEPTH];
  logic [15:0]         r_desc [NDESC];
  logic [ADDR_W:0]     r_wr_ptr, r_wr_base, r_rd_rel, r_rd_ptr;
  logic [15:0]         r_cur_len, r_sent, r_byte_num;
  logic                r_drop_flag, r_commit, r_drop, r_abort;
  logic [LEN_FIFO_W:0] r_dq_wr, r_dq_rd;
  logic [1:0]          r_state;
  logic [TO_W-1:0]     r_wcnt;
  logic [7:0]          r_tx_data;

  logic [ADDR_W:0]     w_used;
  logic [LEN_FIFO_W:0] w_dq_cnt;
  logic                w_dq_full, w_dq_empty, w_reject, w_wr_ok, w_push, w_rewind;
  logic                w_rd_fire, w_timeout, w_release;

  // The extra wrap bit makes used == DEPTH distinguishable from empty.
  assign w_used     = r_wr_ptr - r_rd_rel;
  assign w_dq_cnt   = r_dq_wr - r_dq_rd;
  assign w_dq_full  = w_dq_cnt[LEN_FIFO_W];
  assign w_dq_empty = (w_dq_cnt == '0);
  assign w_reject   = w_used[ADDR_W] || (r_cur_len == 16'(MAX_PKT_LEN));
  assign w_wr_ok    = bus.wr_en && !w_reject;
  assign w_push     = bus.wr_en && bus.wr_last && !(r_drop_flag || w_reject) && !w_dq_full;
  assign w_rewind   = bus.wr_en && bus.wr_last && !w_push;

  assign w_rd_fire  = (r_state == S_SEND) && bus.tx_req && (r_sent != r_byte_num);
  assign w_timeout  = (r_state == S_WAIT) && !bus.tx_done && (r_wcnt == TO_W'(TIMEOUT_CYC - 1));
  assign w_release  = (((r_state == S_SEND) || (r_state == S_WAIT)) && bus.tx_done) || w_timeout;

  always_ff @(posedge i_clk) begin
    if (w_wr_ok && !i_rst) r_ram[r_wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) r_desc[r_dq_wr[LEN_FIFO_W-1:0]] <= r_cur_len + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)          r_tx_data <= '0;
    else if (w_rd_fire) r_tx_data <= r_ram[r_rd_ptr[ADDR_W-1:0]];
  end

  // Write side: bytes land tentatively, committed only when the whole packet fits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_wr_base   <= '0;
      r_cur_len   <= '0;
      r_drop_flag <= 1'b0;
      r_dq_wr     <= '0;
      r_commit    <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_commit <= w_push;
      r_drop   <= w_rewind;
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_wr_base <= r_wr_ptr + 1'b1;
        r_cur_len <= '0;
        r_dq_wr   <= r_dq_wr + 1'b1;
      end else if (w_rewind) begin
        r_wr_ptr    <= r_wr_base;
        r_cur_len   <= '0;
        r_drop_flag <= 1'b0;
      end else if (bus.wr_en) begin
        if (w_reject) begin
          r_drop_flag <= 1'b1;
        end else begin
          r_wr_ptr  <= r_wr_ptr + 1'b1;
          r_cur_len <= r_cur_len + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_rd_rel   <= '0;
      r_dq_rd    <= '0;
      r_sent     <= '0;
      r_byte_num <= '0;
      r_wcnt     <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_abort <= w_timeout;
      case (r_state)
        S_IDLE: if (!w_dq_empty) begin
          r_byte_num <= r_desc[r_dq_rd[LEN_FIFO_W-1:0]];
          r_rd_ptr   <= r_rd_rel;
          r_sent     <= '0;
          r_state    <= S_START;
        end
        S_START: r_state <= S_SEND;
        S_SEND: begin
          if (w_rd_fire) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_sent   <= r_sent + 16'd1;
            if ((r_sent + 16'd1) == r_byte_num) begin
              r_state <= S_WAIT;
              r_wcnt  <= '0;
            end
          end
        end
        default: r_wcnt <= r_wcnt + 1'b1;
      endcase
      // Release wins over every transition above, including a timeout.
      if (w_release) begin
        r_state  <= S_IDLE;
        r_dq_rd  <= r_dq_rd + 1'b1;
        r_rd_rel <= r_rd_rel + r_byte_num[ADDR_W:0];
      end
    end
  end

  assign bus.wr_commit   = r_commit;
  assign bus.wr_drop     = r_drop;
  assign bus.tx_start_en = (r_state == S_START);
  assign bus.tx_byte_num = r_byte_num;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_abort    = r_abort;
  assign bus.pkt_pending = w_dq_cnt;

`ifdef UDP_TX_PKT_BUF_STATS_EN
  logic [31:0] r_stat_tx, r_stat_dr;
  logic [15:0] r_stat_ab;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_tx <= '0;
      r_stat_dr <= '0;
      r_stat_ab <= '0;
    end else begin
      if (w_release && !(&r_stat_tx)) r_stat_tx <= r_stat_tx + 32'd1;
      if (w_rewind  && !(&r_stat_dr)) r_stat_dr <= r_stat_dr + 32'd1;
      if (w_timeout && !(&r_stat_ab)) r_stat_ab <= r_stat_ab + 16'd1;
    end
  end

  assign o_stat_tx_pkts = r_stat_tx;
  assign o_stat_drops   = r_stat_dr;
  assign o_stat_aborts  = r_stat_ab;
`endif
endmodule

// File: tb/tb_udp_tx_pkt_buf.sv
// Bench for udp_tx_pkt_buf: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based packet model.
module tb_udp_tx_pkt_buf;
  localparam int TO    = 300;
  localparam int MAXL  = 1472;
  localparam int DEPTH = 2048;
  localparam int NDESC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udp_tx_pkt_buf_if #(.LEN_FIFO_W(3)) bus();

`ifdef UDP_TX_PKT_BUF_STATS_EN
  logic [31:0] st_tx, st_dr;
  logic [15:0] st_ab;
`endif

  udp_tx_pkt_buf #(
    .ADDR_W(11), .LEN_FIFO_W(3), .MAX_PKT_LEN(MAXL), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
`ifdef UDP_TX_PKT_BUF_STATS_EN
    , .o_stat_tx_pkts(st_tx), .o_stat_drops(st_dr), .o_stat_aborts(st_ab)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  bit wdone  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet-level model: committed bytes live in one queue, lengths in another.
  logic [7:0]  m_bytes[$];
  logic [7:0]  cur[$];
  int          mq_len[$];
  bit          bad;
  int          ph, sent, wcnt;
  int          s_tx, s_dr, s_ab;
  logic        e_commit = 0, e_drop = 0, e_abort = 0, e_start = 0;
  logic [15:0] e_num = 0;
  logic [7:0]  e_data = 0;
  int          e_pend = 0;

  task automatic model_step();
    int used;
    bit rel;
    if (rst) begin
      m_bytes.delete(); cur.delete(); mq_len.delete();
      bad = 0; ph = 0; sent = 0; wcnt = 0; s_tx = 0; s_dr = 0; s_ab = 0;
      e_commit = 0; e_drop = 0; e_abort = 0; e_start = 0; e_num = 0; e_data = 0; e_pend = 0;
      return;
    end
    used = m_bytes.size() + cur.size();
    e_commit = 0; e_drop = 0; e_abort = 0; rel = 0;
    case (ph)
      0: if (mq_len.size() > 0) begin e_num = 16'(mq_len[0]); sent = 0; ph = 1; end
      1: ph = 2;
      2: begin
        if (bus.tx_req && sent < int'(e_num)) begin e_data = m_bytes[sent]; sent++; end
        if (bus.tx_done) rel = 1;
        else if (sent == int'(e_num)) begin ph = 3; wcnt = 0; end
      end
      default: begin
        if (bus.tx_done) rel = 1;
        else if (wcnt == TO - 1) begin e_abort = 1; rel = 1; s_ab++; end
        else wcnt++;
      end
    endcase
    if (bus.wr_en) begin
      if (used == DEPTH || cur.size() == MAXL) bad = 1;
      else cur.push_back(bus.wr_data);
      if (bus.wr_last) begin
        if (!bad && mq_len.size() < NDESC) begin
          foreach (cur[i]) m_bytes.push_back(cur[i]);
          mq_len.push_back(cur.size());
          e_commit = 1;
        end else begin
          e_drop = 1; s_dr++;
        end
        cur.delete(); bad = 0;
      end
    end
    if (rel) begin
      for (int i = 0; i < int'(e_num); i++) void'(m_bytes.pop_front());
      void'(mq_len.pop_front());
      ph = 0; s_tx++;
    end
    e_start = (ph == 1);
    e_pend  = mq_len.size();
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("wr_commit",   bus.wr_commit,   e_commit);
      chk("wr_drop",     bus.wr_drop,     e_drop);
      chk("tx_start_en", bus.tx_start_en, e_start);
      chk("tx_byte_num", bus.tx_byte_num, e_num);
      chk("tx_data",     bus.tx_data,     e_data);
      chk("tx_abort",    bus.tx_abort,    e_abort);
      chk("pkt_pending", bus.pkt_pending, e_pend);
`ifdef UDP_TX_PKT_BUF_STATS_EN
      chk("stat_tx_pkts", st_tx, s_tx);
      chk("stat_drops",   st_dr, s_dr);
      chk("stat_aborts",  st_ab, s_ab);
`endif
    end
  end

  task automatic write_pkt(input int len, input bit rnd, input int gap, input bit last_en,
                           output bit c, output bit d);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        bus.wr_en = 0; bus.wr_last = 0;
        @(negedge clk);
      end
      bus.wr_en   = 1;
      bus.wr_data = rnd ? 8'($urandom) : 8'(i);
      bus.wr_last = last_en && (i == len - 1);
    end
    @(negedge clk);
    bus.wr_en = 0; bus.wr_last = 0;
    c = bus.wr_commit;
    d = bus.wr_drop;
  endtask

  task automatic wait_start(input int lim, output int w);
    w = 0;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (bus.tx_start_en) begin w = i; break; end
    end
  endtask

  // Issues n accepted requests (pct% density), then extra surplus ones.
  task automatic serve(input int n, input int pct, input int extra, input bit lit);
    int k = 0;
    bit prev = 0;
    while (k < n) begin
      @(negedge clk);
      if (lit && prev) chk("lit_data", bus.tx_data, k - 1);
      bus.tx_req = ($urandom_range(0, 99) < pct);
      prev = bus.tx_req;
      if (prev) k++;
    end
    for (int e = 0; e < extra; e++) begin @(negedge clk); bus.tx_req = 1; end
    @(negedge clk);
    if (lit && prev && extra == 0) chk("lit_data", bus.tx_data, k - 1);
    bus.tx_req = 0;
  endtask

  task automatic send_done();
    @(negedge clk); bus.tx_done = 1;
    @(negedge clk); bus.tx_done = 0;
  endtask

  task automatic wait_abort(output int got);
    got = 0;
    for (int i = 1; i <= TO + 20; i++) begin
      @(negedge clk);
      if (bus.tx_abort) begin got = i; break; end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit c, d;
    int w, got;
    int lens[3];
    bus.wr_en = 0; bus.wr_data = 0; bus.wr_last = 0; bus.tx_req = 0; bus.tx_done = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_start", bus.tx_start_en, 0);
    chk("rst_pending", bus.pkt_pending, 0);
    chk("rst_data", bus.tx_data, 0);
    rst = 0;

    // single packet, incrementing payload
    write_pkt(18, 0, 0, 1, c, d);
    chk("t1_commit", c, 1);
    wait_start(20, w);
    chk("t1_start_lat", w, 1);
    chk("t1_byte_num", bus.tx_byte_num, 18);
    serve(18, 100, 0, 1);
    chk("t1_pend_before", bus.pkt_pending, 1);
    send_done();
    chk("t1_pend_after", bus.pkt_pending, 0);

    // three queued packets while the transmitter stalls
    lens = '{100, 200, 300};
    for (int j = 0; j < 3; j++) write_pkt(lens[j], 1, 0, 1, c, d);
    chk("t2_pending", bus.pkt_pending, 3);
    chk("t2_num0", bus.tx_byte_num, 100);
    for (int j = 0; j < 3; j++) begin
      serve(lens[j], 70, 0, 0);
      send_done();
      if (j < 2) begin
        wait_start(10, w);
        chk("t2_gap", w, 1);
        chk("t2_num", bus.tx_byte_num, lens[j+1]);
      end
    end

    // overflow drop, then recovery once space frees
    write_pkt(1400, 1, 0, 1, c, d);
    chk("t3_commit1400", c, 1);
    write_pkt(700, 1, 0, 1, c, d);
    chk("t3_drop700", d, 1);
    chk("t3_nocommit700", c, 0);
    chk("t3_pending", bus.pkt_pending, 1);
    serve(1400, 100, 0, 0);
    send_done();
    write_pkt(600, 1, 0, 1, c, d);
    chk("t3_commit600", c, 1);
    wait_start(10, w);
    chk("t3_num600", bus.tx_byte_num, 600);
    serve(600, 100, 1, 0);
    send_done();

    // oversize boundary
    write_pkt(MAXL + 1, 1, 0, 1, c, d);
    chk("t4_drop1473", d, 1);
    chk("t4_pend0", bus.pkt_pending, 0);
    write_pkt(MAXL, 1, 0, 1, c, d);
    chk("t4_commit1472", c, 1);
    wait_start(10, w);
    chk("t4_num", bus.tx_byte_num, MAXL);
    serve(MAXL, 100, 0, 0);
    send_done();

    // descriptor FIFO full
    for (int j = 0; j < 9; j++) begin
      write_pkt(4, 1, 0, 1, c, d);
      if (j < 8) chk("t5_commit", c, 1);
      else       chk("t5_drop_full", d, 1);
    end
    chk("t5_pending", bus.pkt_pending, 8);
    for (int j = 0; j < 8; j++) begin
      if (j > 0) begin wait_start(10, w); chk("t5_start", w, 1); end
      serve(4, 100, 0, 0);
      send_done();
    end
    chk("t5_drained", bus.pkt_pending, 0);

    // watchdog timeout, next packet still launches
    write_pkt(10, 1, 0, 1, c, d);
    write_pkt(5, 1, 0, 1, c, d);
    serve(10, 100, 0, 0);
    wait_abort(got);
    chk("t6_abort_lat", got, TO);
    chk("t6_pending", bus.pkt_pending, 1);
    wait_start(10, w);
    chk("t6_next_start", w, 1);
    chk("t6_num", bus.tx_byte_num, 5);
    serve(5, 100, 0, 0);
    send_done();

    // reset mid-SEND with a partial packet in flight
    write_pkt(50, 0, 0, 1, c, d);
    wait_start(10, w);
    serve(5, 100, 0, 1);
    write_pkt(3, 1, 0, 0, c, d);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("t7_pending", bus.pkt_pending, 0);
    chk("t7_data", bus.tx_data, 0);
    chk("t7_num", bus.tx_byte_num, 0);
    chk("t7_start", bus.tx_start_en, 0);
    wait_start(30, w);
    chk("t7_no_start", w, 0);
    write_pkt(7, 0, 0, 1, c, d);
    chk("t7_commit", c, 1);
    wait_start(10, w);
    chk("t7_num7", bus.tx_byte_num, 7);
    serve(7, 100, 0, 1);
    send_done();

    // randomized concurrent traffic
    fork
      begin
        bit rc, rd;
        int len, r;
        for (int p = 0; p < 40; p++) begin
          r   = $urandom_range(0, 99);
          len = (r < 8) ? $urandom_range(1400, 1480) : $urandom_range(1, 200);
          write_pkt(len, 1, 30, 1, rc, rd);
        end
        wdone = 1;
      end
      begin
        int rw, n, r, pct, ab, loops;
        loops = 0;
        while (1) begin
          wait_start(64, rw);
          if (rw != 0) begin
            n   = int'(bus.tx_byte_num);
            r   = $urandom_range(0, 99);
            pct = $urandom_range(40, 100);
            if (r < 5) begin
              serve(n, pct, 0, 0);
              wait_abort(ab);
              if (ab == 0) chk("rand_abort_seen", 0, 1);
            end else if (r < 10) begin
              serve(n / 2, pct, 0, 0);
              send_done();
            end else begin
              serve(n, pct, $urandom_range(0, 2), 0);
              repeat ($urandom_range(0, 4)) @(negedge clk);
              send_done();
            end
          end else if (wdone && bus.pkt_pending == 0) begin
            break;
          end
          loops++;
          if (loops > 2000) begin chk("rand_progress", 0, 1); break; end
        end
      end
    join
    chk("final_pending", bus.pkt_pending, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/udp_tx_pkt_buf.md
Name: udp_tx_pkt_buf

Overview:
- Store-and-forward packet buffer placed directly upstream of the UDP transmit wrapper, in the gmii_tx_clk domain.
- User logic writes complete payloads byte by byte. The block queues committed packets and launches each one with a tx_start_en pulse plus a stable tx_byte_num.
- It supplies tx_data in response to tx_req and releases buffer space on tx_done.

Parameters:
- ADDR_W, 11, log2 of payload RAM depth in bytes (2048).
- LEN_FIFO_W, 3, log2 of the number of queued packet descriptors (8).
- MAX_PKT_LEN, 1472, largest accepted payload in bytes; longer packets are dropped.
- TIMEOUT_CYC, 65535, cycles to wait for tx_done after the last byte is read before aborting.

Ports:
- clk  in  1  gmii_tx_clk; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  payload byte valid
- wr_data  in  8  payload byte
- wr_last  in  1  qualifies wr_en; marks the final byte of the packet
- wr_commit  out  1  1-cycle pulse: packet accepted and queued
- wr_drop  out  1  1-cycle pulse: packet discarded (overflow, oversize, or descriptor FIFO full)
- tx_start_en  out  1  1-cycle pulse to the UDP transmitter
- tx_byte_num  out  16  payload length; held stable from tx_start_en until tx_done
- tx_req  in  1  byte request from the transmitter
- tx_data  out  8  payload byte, valid the cycle after tx_req
- tx_done  in  1  packet transmission complete
- tx_abort  out  1  1-cycle pulse on watchdog timeout
- pkt_pending  out  LEN_FIFO_W+1  number of committed packets not yet released

Behaviour:
- Reset values:
  - All outputs 0.
  - Pointers cleared; write side and read side both empty.
  - FSM in IDLE.
  - A reset mid-packet discards all stored and partial data; no commit or drop pulse is emitted.
- Write side:
  - Pointers: wr_ptr (tentative), wr_base (start of current packet), rd_rel (oldest unreleased byte).
  - used = wr_ptr - rd_rel, modulo 2^ADDR_W, with one extra wrap bit so that full and empty are distinguishable.
  - On wr_en: if used == 2^ADDR_W, or the current length is already MAX_PKT_LEN, set the sticky drop flag and do not write. Otherwise write RAM[wr_ptr], then increment wr_ptr and the current length.
  - On wr_en & wr_last, if drop flag clear and the descriptor FIFO is not full:
    - push the length;
    - wr_base <= the new wr_ptr;
    - pulse wr_commit the next cycle.
  - On wr_en & wr_last otherwise:
    - wr_ptr <= wr_base;
    - clear the length and the drop flag;
    - pulse wr_drop the next cycle.
  - The drop check includes the byte arriving with wr_last.
  - Pointers wrap naturally at 2^ADDR_W.
- Read FSM:
  - IDLE: when the descriptor FIFO is not empty, set tx_byte_num <= head length and rd_ptr <= rd_rel; go to START.
  - START: tx_start_en = 1 for exactly one cycle; go to SEND.
  - SEND: on each tx_req, read RAM[rd_ptr] into the tx_data register (1-cycle latency), increment rd_ptr and the sent count. When the count reaches tx_byte_num, go to WAIT_DONE.
  - WAIT_DONE: count cycles. On tx_done, release. At TIMEOUT_CYC, pulse tx_abort and release anyway.
  - release = pop descriptor, rd_rel <= rd_rel + tx_byte_num, return to IDLE.
  - tx_done in SEND also releases immediately.
  - tx_req beyond tx_byte_num is ignored; tx_data holds its last value.
  - tx_byte_num holds its value in IDLE.
- Simultaneous events:
  - A commit and a release in the same cycle both take effect.
  - pkt_pending is unchanged in that cycle.
  - Space freed in cycle N is usable by wr_en in cycle N+1.
- Back-to-back packets: the minimum gap from tx_done to the next tx_start_en is 2 cycles (IDLE, START).

Optional Feature:
- Macro: UDP_TX_PKT_BUF_STATS_EN.
- Defined:
  - adds outputs stat_tx_pkts (32), stat_drops (32) and stat_aborts (16);
  - each is incremented on release, wr_drop and tx_abort respectively, saturating at maximum;
  - cleared by rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single packet:
  - Write 18 bytes 0x00..0x11 with wr_last on 0x11 -> wr_commit pulse; tx_start_en 1 cycle with tx_byte_num=18.
  - 18 tx_req -> tx_data 0x00..0x11, each one cycle after its tx_req.
  - tx_done -> pkt_pending 1→0.
- Queueing:
  - Commit three packets of 100, 200 and 300 bytes while the transmitter stalls -> pkt_pending=3.
  - Packets are sent in order, each with the correct tx_byte_num, and there is a 2-cycle gap after each tx_done.
- Overflow drop:
  - Fill with 1400 bytes committed and unsent, then write 700 bytes -> wr_drop.
  - wr_ptr is rewound; pkt_pending stays 1.
  - The next 600-byte packet commits after the first is released.
- Oversize: a 1473-byte packet -> wr_drop, no descriptor pushed; a following 1472-byte packet -> wr_commit.
- Timeout: after all bytes are read, hold tx_done low -> tx_abort at TIMEOUT_CYC, space is released, and the next packet starts.
- Reset mid-SEND: assert rst after 5 of 50 bytes -> all outputs 0, pkt_pending=0, no tx_start_en until a new commit.
